// File: rtl/mem_stage.sv
// Memory stage: data RAM, load/store lanes, multi-cycle access FSM, WB register.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_m,
  output logic              stall_m,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        size_m,
  input  logic              unsigned_m,
  input  logic [DATA_W-1:0] AluOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [4:0]        WriteRegM,
  output logic              valid_w,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] AluOutW,
  output logic [4:0]        WriteRegW,
  output logic              misalign_w
);
  localparam int NB = DATA_W / 8;
  localparam int AB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [2:0] CNT0 =
    (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     idx;
  logic [AB-1:0]     off_a;
  logic [NB-1:0]     be;
  logic              acc, mis, multi, done, we;
  logic [DATA_W-1:0] rsh, wsh, keep, ldata;
  logic              sgn;

  assign idx = AluOutM[IW+AB-1:AB];
  assign acc = valid_m & (MemReadM | MemWriteM);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign mis = acc & (
    ((size_m == 2'b01) & AluOutM[0]) |
    (size_m[1] & (|AluOutM[AB-1:0])));
`else
  assign mis = 1'b0;
`endif

  // Offsets below the access size are dropped (aligned down)
  always_comb begin
    off_a = AluOutM[AB-1:0];
    be    = '0;
    unique case (1'b1)
      size_m == 2'b00: be = NB'(1) << off_a;
      size_m == 2'b01: begin
        off_a[0] = 1'b0;
        be       = NB'(3) << off_a;
      end
      default: begin
        off_a = '0;
        be    = '1;
      end
    endcase
  end

  assign rsh = mem[idx] >> {off_a, 3'b000};
  assign wsh = WriteDataM << {off_a, 3'b000};

  always_comb begin
    keep = '1;
    sgn  = 1'b0;
    unique case (1'b1)
      size_m == 2'b00: begin
        keep = DATA_W'(8'hff);
        sgn  = rsh[7];
      end
      size_m == 2'b01: begin
        keep = DATA_W'(16'hffff);
        sgn  = rsh[15];
      end
      default: begin
        keep = '1;
        sgn  = 1'b0;
      end
    endcase
    ldata = (rsh & keep) |
      (~keep & {DATA_W{sgn & ~unsigned_m}});
  end

  assign multi = acc & ~mis & (MEM_LAT > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: if (multi) begin
        state_nx = BUSY;
        cnt_nx   = CNT0;
      end
      BUSY: if (cnt == 3'd0) state_nx = IDLE;
            else cnt_nx = cnt - 3'd1;
    endcase
  end

  always_comb begin
    stall_m = rst_n &
      ((state == IDLE) ? multi : (cnt != 3'd0));
  end

  assign done = rst_n & valid_m & ~stall_m;
  assign we   = done & MemWriteM & ~mis;

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wsh[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_w    <= 1'b0;
      RegWriteW  <= 1'b0;
      MemToRegW  <= 1'b0;
      ReadDataW  <= '0;
      AluOutW    <= '0;
      WriteRegW  <= 5'd0;
      misalign_w <= 1'b0;
    end else if (done) begin
      valid_w    <= 1'b1;
      RegWriteW  <= RegWriteM & ~mis;
      MemToRegW  <= MemToRegM;
      ReadDataW  <= (MemReadM & ~mis) ? ldata : '0;
      AluOutW    <= AluOutM;
      WriteRegW  <= WriteRegM;
      misalign_w <= mis;
    end else begin
      valid_w    <= 1'b0;
      RegWriteW  <= 1'b0;
      misalign_w <= 1'b0;
    end
  end
endmodule
